// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch AXI-lite master.
// Optional feature macro used by the fetch stage: FETCH_RESP_CHECK_EN.
package fetch_pkg;

  localparam int XLEN_ADDR = 32;
  localparam int INST_W    = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    REQ   = 2'b00,
    WAIT  = 2'b01,
    STALL = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [XLEN_ADDR-1:0] pc;
    logic                 fault;
  } fetch_entry_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: wrap-around pointers carry an extra MSB so full and empty
// are told apart; flush empties it and wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;

  // Storage and pointer update.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  assign count      = wr_ptr_r - rd_ptr_r;
  assign head_valid = (count != '0);
  assign head       = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/fetch_axi_master.sv
// Instruction fetch over single-beat AXI-lite reads into a prefetch FIFO,
// with redirect/flush. Define FETCH_RESP_CHECK_EN to fault and halt on non-OKAY rresp.
module fetch_axi_master
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  output logic [31:0] araddr,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic        rvalid,
  input  logic [1:0]  rresp,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        fetch_halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_STALL = STALL;

  logic [1:0]    state_r, state_nxt_s;
  logic [31:0]   pc_r, pc_nxt_s, araddr_r;
  logic          arvalid_r, drop_r, drop_nxt_s, halted_r, halted_nxt_s;
  logic          fire_s, push_s, pop_s, resp_err_s, head_valid_s, unused_s;
  logic [CW-1:0] count_s;
  fetch_entry_t  push_data_s, head_s;

  assign fire_s = arvalid_r & arready;
  assign pop_s  = head_valid_s & inst_ready & ~redirect_valid;

`ifdef FETCH_RESP_CHECK_EN
  assign resp_err_s   = resp_is_err(rresp);
  assign inst_fault   = head_s.fault;
  assign fetch_halted = halted_r;
  assign unused_s     = ^rdata[63:32];
`else
  assign resp_err_s   = 1'b0;
  assign inst_fault   = 1'b0;
  assign fetch_halted = 1'b0;
  assign unused_s     = ^{rdata[63:32], rresp, head_s.fault};
`endif

  // Next-state, pc, drop and halt decisions; redirect overrides normal flow.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    drop_nxt_s   = drop_r;
    halted_nxt_s = halted_r;
    push_s       = 1'b0;
    push_data_s  = '{inst: rdata[31:0], pc: pc_r, fault: resp_err_s};
    if (redirect_valid) begin
      pc_nxt_s     = {redirect_pc[31:2], 2'b00};
      halted_nxt_s = 1'b0;
      case (state_r)
        S_WAIT: begin
          // A response arriving with the redirect is the one being discarded.
          drop_nxt_s  = ~rvalid;
          state_nxt_s = rvalid ? S_REQ : S_WAIT;
        end
        S_REQ: begin
          // A presented request keeps its address until taken; its reply is dropped.
          drop_nxt_s  = arvalid_r;
          state_nxt_s = fire_s ? S_WAIT : S_REQ;
        end
        default: begin
          drop_nxt_s  = 1'b0;
          state_nxt_s = S_REQ;
        end
      endcase
    end else begin
      case (state_r)
        S_REQ: begin
          state_nxt_s = fire_s ? S_WAIT : S_REQ;
        end
        S_WAIT: begin
          if (rvalid && drop_r) begin
            drop_nxt_s  = 1'b0;
            state_nxt_s = ((count_s < DEPTH_C) && !halted_r) ? S_REQ : S_STALL;
          end else if (rvalid) begin
            push_s       = 1'b1;
            pc_nxt_s     = pc_r + 32'd4;
            halted_nxt_s = halted_r | resp_err_s;
            state_nxt_s  = (((count_s + CW'(1)) < DEPTH_C) && !halted_nxt_s) ? S_REQ : S_STALL;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_STALL: begin
          state_nxt_s = ((count_s < DEPTH_C) && !halted_r) ? S_REQ : S_STALL;
        end
        default: begin
          state_nxt_s = S_REQ;
        end
      endcase
    end
  end

  // Control registers and the registered AXI address channel.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= S_REQ;
      pc_r      <= RESET_PC;
      araddr_r  <= RESET_PC;
      arvalid_r <= 1'b0;
      drop_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      drop_r    <= drop_nxt_s;
      halted_r  <= halted_nxt_s;
      arvalid_r <= (state_nxt_s == S_REQ);
      if (!arvalid_r || fire_s) begin
        araddr_r <= pc_nxt_s;
      end else begin
        araddr_r <= araddr_r;
      end
    end
  end

  assign arvalid = arvalid_r;
  assign araddr  = araddr_r;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign inst_valid = head_valid_s;
  assign inst       = head_s.inst;
  assign inst_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_axi_master.sv
// Directed bench for fetch_axi_master with a one-cycle-latency memory responder.
module tb_fetch_axi_master;

  logic        CLK;
  logic        RST_N;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic [63:0] rdata;
  logic        rvalid;
  logic [1:0]  rresp;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        fetch_halted;

  int errors = 0;
  int checks = 0;

  logic [31:0] fault_addr = 32'h0000_0048;
  logic        mem_hs;
  logic [31:0] mem_a;

  fetch_axi_master #(
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .arvalid        (arvalid),
    .araddr         (araddr),
    .arready        (arready),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .rresp          (rresp),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .fetch_halted   (fetch_halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0013;
      32'h0000_0004: mem_word = 32'h0000_0093;
      32'h0000_0008: mem_word = 32'h0000_0113;
      32'h0000_000C: mem_word = 32'h0000_0193;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory: a request accepted at an edge is answered for exactly the next cycle.
  initial begin
    rvalid = 1'b0;
    rdata  = 64'd0;
    rresp  = 2'b00;
    forever begin
      @(negedge CLK);
      mem_hs = arvalid && arready;
      mem_a  = araddr;
      @(posedge CLK);
      #1;
      if (mem_hs) begin
        rvalid = 1'b1;
        rdata  = {32'hDEAD_BEEF, mem_word(mem_a)};
        rresp  = (mem_a == fault_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rdata  = 64'd0;
        rresp  = 2'b00;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int waited;
    RST_N          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    arready        = 1'b0;
    inst_ready     = 1'b0;
    tick();
    tick();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_fault", {31'd0, inst_fault}, 32'd0);
    chk("rst_halted", {31'd0, fetch_halted}, 32'd0);

    // Release; memory refuses the first request cycle.
    RST_N = 1'b1;
    tick();
    chk("first_arvalid", {31'd0, arvalid}, 32'd1);
    chk("first_araddr", araddr, 32'h0);
    tick();
    chk("held_arvalid", {31'd0, arvalid}, 32'd1);
    chk("held_araddr", araddr, 32'h0);
    arready    = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("wait_arvalid", {31'd0, arvalid}, 32'd0);

    // Sequential fetch, one instruction every two cycles.
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_valid", {31'd0, inst_valid}, 32'd1);
      chk("seq_inst", inst, mem_word(32'(i * 4)));
      chk("seq_pc", inst_pc, 32'(i * 4));
      chk("seq_fault", {31'd0, inst_fault}, 32'd0);
      tick();
      chk("seq_gap_valid", {31'd0, inst_valid}, 32'd0);
    end

    // Decode stalls: four entries fill the FIFO and fetch stops.
    inst_ready = 1'b0;
    repeat (7) tick();
    chk("full_arvalid", {31'd0, arvalid}, 32'd0);
    chk("full_head_pc", inst_pc, 32'h10);
    repeat (2) tick();
    chk("stall_arvalid", {31'd0, arvalid}, 32'd0);
    chk("stall_head_inst", inst, mem_word(32'h10));
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("pop_head_pc", inst_pc, 32'h14);
    chk("pop_not_credited", {31'd0, arvalid}, 32'd0);
    tick();
    chk("resume_arvalid", {31'd0, arvalid}, 32'd1);
    chk("resume_araddr", araddr, 32'h20);

    // Redirect while a request is presented but not yet accepted.
    arready        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("redir_hold_arvalid", {31'd0, arvalid}, 32'd1);
    chk("redir_hold_araddr", araddr, 32'h20);
    chk("redir_flush", {31'd0, inst_valid}, 32'd0);
    arready = 1'b1;
    tick();
    tick();
    chk("drop_no_push", {31'd0, inst_valid}, 32'd0);
    chk("redir_arvalid", {31'd0, arvalid}, 32'd1);
    chk("redir_araddr", araddr, 32'h100);
    tick();
    tick();
    chk("redir_valid", {31'd0, inst_valid}, 32'd1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_inst", inst, mem_word(32'h100));

    // Redirect coinciding with a response in WAIT and with a pop.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_pop_empty", {31'd0, inst_valid}, 32'd0);
    chk("redir2_araddr", araddr, 32'h40);
    tick();
    tick();
    chk("redir2_pc", inst_pc, 32'h40);
    chk("redir2_inst", inst, mem_word(32'h40));

    // Error response at 0x48.
    repeat (4) tick();
    chk("err_pc", inst_pc, 32'h48);
`ifdef FETCH_RESP_CHECK_EN
    chk("err_fault", {31'd0, inst_fault}, 32'd1);
    chk("err_halted", {31'd0, fetch_halted}, 32'd1);
    chk("err_arvalid", {31'd0, arvalid}, 32'd0);
    repeat (2) tick();
    chk("halt_arvalid", {31'd0, arvalid}, 32'd0);
    chk("halt_sticky", {31'd0, fetch_halted}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0000;
    tick();
    redirect_valid = 1'b0;
    chk("unhalt", {31'd0, fetch_halted}, 32'd0);
    chk("unhalt_arvalid", {31'd0, arvalid}, 32'd1);
    chk("unhalt_araddr", araddr, 32'h0);
    tick();
    tick();
    chk("unhalt_pc", inst_pc, 32'h0);
    chk("unhalt_inst", inst, 32'h0000_0013);
    chk("unhalt_fault", {31'd0, inst_fault}, 32'd0);
`else
    chk("err_fault_tied", {31'd0, inst_fault}, 32'd0);
    chk("err_halted_tied", {31'd0, fetch_halted}, 32'd0);
    chk("err_arvalid", {31'd0, arvalid}, 32'd1);
    chk("err_araddr", araddr, 32'h4C);
`endif

    // Reset while a response is pending in WAIT.
    waited = 0;
    while (!arvalid && waited < 10) begin
      tick();
      waited++;
    end
    chk("pre_reset_arvalid", {31'd0, arvalid}, 32'd1);
    tick();
    RST_N = 1'b0;
    tick();
    chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rst_araddr", araddr, 32'h0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_pc", inst_pc, 32'h0);
    chk("mid_rst_halted", {31'd0, fetch_halted}, 32'd0);
    RST_N = 1'b1;
    tick();
    chk("restart_arvalid", {31'd0, arvalid}, 32'd1);
    chk("restart_araddr", araddr, 32'h0);
    chk("restart_empty", {31'd0, inst_valid}, 32'd0);
    tick();
    tick();
    chk("restart_pc", inst_pc, 32'h0);
    chk("restart_inst", inst, 32'h0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
